// File: rtl/ctrl_pipeline.sv
// Decodes the ID opcode and carries control bits through the ID/EX, EX/MEM and MEM/WB registers, with load-use stall.
// Latency: decode appears on ex_* after 1 edge, mem_* after 2 and wb_* after 3, not counting held edges.
// hold_i freezes every stage; a flush or load-use stall loads a bubble into ID/EX while EX/MEM and MEM/WB advance.
module ctrl_pipeline #(
    parameter int ALUOP_W = 3,
    parameter int EN_UJ   = 1,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         Op_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic [REG_W-1:0]   rs1_i,
    input  logic [REG_W-1:0]   rs2_i,
    input  logic               hold_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic [ALUOP_W-1:0] ex_ALUOp_o,
    output logic               ex_ALUSrc_o,
    output logic               ex_Branch_o,
    output logic               ex_Jump_o,
    output logic [REG_W-1:0]   ex_rd_o,
    output logic [REG_W-1:0]   mem_rd_o,
    output logic [REG_W-1:0]   wb_rd_o,
    output logic               mem_MemRead_o,
    output logic               mem_MemWrite_o,
    output logic               wb_RegWrite_o,
    output logic               wb_MemtoReg_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_SUB  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_RF   = 3'b010;
    localparam logic [2:0] ALU_IF   = 3'b011;
    localparam logic [2:0] ALU_IMM  = 3'b100;
    localparam logic [2:0] ALU_PC4  = 3'b101;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               branch;
        logic               jump;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic [REG_W-1:0]   rd;
    } id_ex_t;

    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rd;
    } mem_wb_t;

    id_ex_t           dec;
    logic             dec_vld;
    logic             rs1_used;
    logic             rs2_used;
    logic             stall;
    id_ex_t           id_ex;
    ex_mem_t          ex_mem;
    mem_wb_t          mem_wb;
    logic [CNT_W-1:0] stall_cnt;

    always_comb begin
        dec      = '0;
        dec_vld  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (Op_i)
            OP_R: begin
                dec_vld       = 1'b1;
                dec.alu_op    = ALUOP_W'(ALU_RF);
                dec.reg_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_I: begin
                dec_vld       = 1'b1;
                dec.alu_op    = ALUOP_W'(ALU_IF);
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                rs1_used      = 1'b1;
            end
            OP_LW: begin
                dec_vld        = 1'b1;
                dec.alu_op     = ALUOP_W'(ALU_ADD);
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_read   = 1'b1;
                rs1_used       = 1'b1;
            end
            OP_SW: begin
                dec_vld       = 1'b1;
                dec.alu_op    = ALUOP_W'(ALU_ADD);
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_BEQ: begin
                dec_vld    = 1'b1;
                dec.alu_op = ALUOP_W'(ALU_SUB);
                dec.branch = 1'b1;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                if (EN_UJ != 0) begin
                    dec_vld       = 1'b1;
                    dec.alu_op    = ALUOP_W'(ALU_PC4);
                    dec.reg_write = 1'b1;
                    dec.jump      = 1'b1;
                    rs1_used      = (Op_i == OP_JALR);
                end
            end
            OP_LUI, OP_AUIPC: begin
                if (EN_UJ != 0) begin
                    dec_vld       = 1'b1;
                    dec.alu_op    = (Op_i == OP_LUI) ? ALUOP_W'(ALU_IMM) : ALUOP_W'(ALU_ADD);
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                end
            end
            default: ;
        endcase
        // Unknown opcodes (and U/J types when disabled) become a full bubble, rd included.
        dec.rd = dec_vld ? rd_i : '0;
    end

    always_comb begin
        stall = id_ex.mem_read && (id_ex.rd != '0)
              && ((rs1_used && (rs1_i == id_ex.rd)) || (rs2_used && (rs2_i == id_ex.rd)))
              && !hold_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            id_ex     <= '0;
            ex_mem    <= '0;
            mem_wb    <= '0;
            stall_cnt <= '0;
        end else if (!hold_i) begin
            mem_wb.reg_write   <= ex_mem.reg_write;
            mem_wb.mem_to_reg  <= ex_mem.mem_to_reg;
            mem_wb.rd          <= ex_mem.rd;
            ex_mem.mem_read    <= id_ex.mem_read;
            ex_mem.mem_write   <= id_ex.mem_write;
            ex_mem.reg_write   <= id_ex.reg_write;
            ex_mem.mem_to_reg  <= id_ex.mem_to_reg;
            ex_mem.rd          <= id_ex.rd;
            id_ex              <= (flush_i || stall) ? '0 : dec;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_o        = stall;
    assign ex_ALUOp_o     = id_ex.alu_op;
    assign ex_ALUSrc_o    = id_ex.alu_src;
    assign ex_Branch_o    = id_ex.branch;
    assign ex_Jump_o      = id_ex.jump;
    assign ex_rd_o        = id_ex.rd;
    assign mem_rd_o       = ex_mem.rd;
    assign mem_MemRead_o  = ex_mem.mem_read;
    assign mem_MemWrite_o = ex_mem.mem_write;
    assign wb_rd_o        = mem_wb.rd;
    assign wb_RegWrite_o  = mem_wb.reg_write;
    assign wb_MemtoReg_o  = mem_wb.mem_to_reg;
    assign stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: table of per-cycle vectors plus hand sequences for hold, flush, saturation and reset.
module tb_ctrl_pipeline;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // expected control bits: {ALUSrc, Branch, Jump, MemRead, MemWrite, RegWrite, MemtoReg}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_R    = 7'b0000010;
    localparam logic [6:0] C_I    = 7'b1000010;
    localparam logic [6:0] C_LW   = 7'b1001011;
    localparam logic [6:0] C_SW   = 7'b1000100;
    localparam logic [6:0] C_BEQ  = 7'b0100000;
    localparam logic [6:0] C_J    = 7'b0010010;

    typedef struct packed {
        logic [2:0] alu;
        logic       src, br, jmp, mr, mw, rw, m2r;
        logic [4:0] rd;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
        logic       hold, flush, exp_stall;
        exp_t       e;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [6:0] Op_i = '0;
    logic [4:0] rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic       hold_i = 1'b0, flush_i = 1'b0;

    logic       stall_o, ex_ALUSrc_o, ex_Branch_o, ex_Jump_o;
    logic [2:0] ex_ALUOp_o;
    logic [4:0] ex_rd_o, mem_rd_o, wb_rd_o;
    logic       mem_MemRead_o, mem_MemWrite_o, wb_RegWrite_o, wb_MemtoReg_o;
    logic [3:0] stall_cnt_o;

    logic       rv_stall, rv_src, rv_br, rv_jmp, rv_mr, rv_mw, rv_rw, rv_m2r;
    logic [1:0] rv_alu;
    logic [4:0] rv_ex_rd, rv_mem_rd, rv_wb_rd;
    logic [3:0] rv_cnt;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk_i = ~clk_i;

    ctrl_pipeline #(.ALUOP_W(3), .EN_UJ(1), .REG_W(5), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .hold_i(hold_i), .flush_i(flush_i), .stall_o(stall_o),
        .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_Branch_o(ex_Branch_o),
        .ex_Jump_o(ex_Jump_o), .ex_rd_o(ex_rd_o), .mem_rd_o(mem_rd_o), .wb_rd_o(wb_rd_o),
        .mem_MemRead_o(mem_MemRead_o), .mem_MemWrite_o(mem_MemWrite_o),
        .wb_RegWrite_o(wb_RegWrite_o), .wb_MemtoReg_o(wb_MemtoReg_o), .stall_cnt_o(stall_cnt_o)
    );

    ctrl_pipeline #(.ALUOP_W(2), .EN_UJ(0), .REG_W(5), .CNT_W(4)) dut_rv (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .hold_i(hold_i), .flush_i(flush_i), .stall_o(rv_stall),
        .ex_ALUOp_o(rv_alu), .ex_ALUSrc_o(rv_src), .ex_Branch_o(rv_br),
        .ex_Jump_o(rv_jmp), .ex_rd_o(rv_ex_rd), .mem_rd_o(rv_mem_rd), .wb_rd_o(rv_wb_rd),
        .mem_MemRead_o(rv_mr), .mem_MemWrite_o(rv_mw),
        .wb_RegWrite_o(rv_rw), .wb_MemtoReg_o(rv_m2r), .stall_cnt_o(rv_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t V(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic hold, input logic flush,
                               input logic stall, input logic [2:0] alu, input logic [6:0] ctl,
                               input logic [4:0] erd);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.hold = hold; v.flush = flush; v.exp_stall = stall;
        v.e.alu = alu;
        {v.e.src, v.e.br, v.e.jmp, v.e.mr, v.e.mw, v.e.rw, v.e.m2r} = ctl;
        v.e.rd = erd;
        return v;
    endfunction

    task automatic sb_clear();
        sb.delete();
        for (int i = 0; i < 3; i++) sb.push_back('0);
        exp_cnt = 0;
    endtask

    task automatic check_stages();
        exp_t ex_e, mem_e, wb_e;
        ex_e = sb[2]; mem_e = sb[1]; wb_e = sb[0];
        chk("ex_stage", {ex_ALUOp_o, ex_ALUSrc_o, ex_Branch_o, ex_Jump_o, ex_rd_o},
            {ex_e.alu, ex_e.src, ex_e.br, ex_e.jmp, ex_e.rd});
        chk("mem_stage", {mem_MemRead_o, mem_MemWrite_o, mem_rd_o}, {mem_e.mr, mem_e.mw, mem_e.rd});
        chk("wb_stage", {wb_RegWrite_o, wb_MemtoReg_o, wb_rd_o}, {wb_e.rw, wb_e.m2r, wb_e.rd});
        chk("stall_cnt", stall_cnt_o, exp_cnt);
    endtask

    // Drive one ID cycle, check the combinational stall, clock it, then check all stages.
    task automatic step(input vec_t v);
        Op_i = v.op; rd_i = v.rd; rs1_i = v.rs1; rs2_i = v.rs2;
        hold_i = v.hold; flush_i = v.flush;
        #2;
        chk("stall_o", stall_o, v.exp_stall);
        @(posedge clk_i);
        #1;
        if (!v.hold) begin
            sb.push_back(v.e);
            void'(sb.pop_front());
            if (v.exp_stall && exp_cnt != 15) exp_cnt++;
        end
        check_stages();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {stall_o, ex_ALUOp_o, ex_ALUSrc_o, ex_Branch_o, ex_Jump_o, ex_rd_o, mem_rd_o,
                   wb_rd_o, mem_MemRead_o, mem_MemWrite_o, wb_RegWrite_o, wb_MemtoReg_o,
                   stall_cnt_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl.push_back(V(OP_R,     3, 1, 2, 0, 0, 0, 3'd2, C_R,    3));
        tbl.push_back(V(OP_LW,    5, 1, 7, 0, 0, 0, 3'd1, C_LW,   5));
        tbl.push_back(V(OP_R,     6, 5, 1, 0, 0, 1, 3'd0, C_NONE, 0));
        tbl.push_back(V(OP_R,     6, 5, 1, 0, 0, 0, 3'd2, C_R,    6));
        tbl.push_back(V(OP_LW,    0, 2, 0, 0, 0, 0, 3'd1, C_LW,   0));
        tbl.push_back(V(OP_R,     7, 0, 0, 0, 0, 0, 3'd2, C_R,    7));
        tbl.push_back(V(OP_LW,    5, 3, 0, 0, 0, 0, 3'd1, C_LW,   5));
        tbl.push_back(V(OP_LUI,   5, 5, 5, 0, 0, 0, 3'd4, C_I,    5));
        tbl.push_back(V(OP_SW,    9, 1, 2, 0, 0, 0, 3'd1, C_SW,   9));
        tbl.push_back(V(OP_BEQ,   4, 1, 2, 0, 0, 0, 3'd0, C_BEQ,  4));
        tbl.push_back(V(OP_JAL,   1, 0, 0, 0, 1, 0, 3'd0, C_NONE, 0));
        tbl.push_back(V(OP_JAL,   1, 0, 0, 0, 0, 0, 3'd5, C_J,    1));
        tbl.push_back(V(OP_JALR,  2, 1, 0, 0, 0, 0, 3'd5, C_J,    2));
        tbl.push_back(V(OP_AUIPC, 8, 0, 0, 0, 0, 0, 3'd1, C_I,    8));
        tbl.push_back(V(OP_BAD,  10, 1, 2, 0, 0, 0, 3'd0, C_NONE, 0));
        tbl.push_back(V(OP_LW,    5, 1, 0, 0, 0, 0, 3'd1, C_LW,   5));
        tbl.push_back(V(OP_SW,    9, 1, 5, 0, 1, 1, 3'd0, C_NONE, 0));
        tbl.push_back(V(OP_I,    11, 5, 0, 0, 0, 0, 3'd3, C_I,   11));
        tbl.push_back(V(OP_LW,   12, 1, 0, 0, 0, 0, 3'd1, C_LW,  12));
        tbl.push_back(V(OP_BEQ,   4, 1, 12, 0, 0, 1, 3'd0, C_NONE, 0));
        tbl.push_back(V(OP_BEQ,   4, 1, 12, 0, 0, 0, 3'd0, C_BEQ, 4));
        tbl.push_back(V(OP_LW,   13, 1, 0, 0, 0, 0, 3'd1, C_LW,  13));
        tbl.push_back(V(OP_JALR,  2, 13, 0, 0, 0, 1, 3'd0, C_NONE, 0));
        tbl.push_back(V(OP_JALR,  2, 13, 0, 0, 0, 0, 3'd5, C_J,   2));
        tbl.push_back(V(OP_LW,   14, 1, 0, 0, 0, 0, 3'd1, C_LW,  14));
        tbl.push_back(V(OP_I,     3, 1, 14, 0, 0, 0, 3'd3, C_I,   3));

        // power-on reset
        #3;
        chk_all_zero("reset_state");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        sb_clear();

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // hold with sw in EX/MEM and a would-be load-use in ID
        step(V(OP_SW, 9, 1, 2, 0, 0, 0, 3'd1, C_SW, 9));
        step(V(OP_LW, 5, 1, 0, 0, 0, 0, 3'd1, C_LW, 5));
        chk("hold_memwrite_0", mem_MemWrite_o, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(V(OP_R, 6, 5, 1, 1, 0, 0, 3'd0, C_NONE, 0));
            chk("hold_memwrite", mem_MemWrite_o, 1'b1);
            chk("hold_cnt", stall_cnt_o, 4'd4);
        end
        step(V(OP_R, 6, 5, 1, 0, 0, 1, 3'd0, C_NONE, 0));
        step(V(OP_R, 6, 5, 1, 0, 0, 0, 3'd2, C_R, 6));

        // RV32I-only instance: R decodes, jal becomes a bubble
        step(V(OP_R, 3, 1, 2, 0, 0, 0, 3'd2, C_R, 3));
        chk("rv_r_aluop", rv_alu, 2'b10);
        step(V(OP_JAL, 1, 0, 0, 0, 0, 0, 3'd5, C_J, 1));
        chk("rv_jal_bubble", {rv_alu, rv_src, rv_br, rv_jmp, rv_ex_rd}, 10'd0);

        // stall counter saturation
        for (int i = 0; i < 21; i++) begin
            step(V(OP_LW, 5, 1, 0, 0, 0, 0, 3'd1, C_LW, 5));
            step(V(OP_R, 6, 5, 1, 0, 0, 1, 3'd0, C_NONE, 0));
            step(V(OP_R, 6, 5, 1, 0, 0, 0, 3'd2, C_R, 6));
        end
        chk("cnt_saturated", stall_cnt_o, 4'd15);

        // asynchronous reset mid-cycle with a load-use pending
        step(V(OP_LW, 5, 1, 0, 0, 0, 0, 3'd1, C_LW, 5));
        Op_i = OP_R; rd_i = 5'd6; rs1_i = 5'd5; rs2_i = 5'd1;
        #2;
        chk("pre_reset_stall", stall_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        sb_clear();

        step(V(OP_R, 3, 1, 2, 0, 0, 0, 3'd2, C_R, 3));
        chk("r_ex", {ex_ALUOp_o, ex_ALUSrc_o}, {3'b010, 1'b0});
        step(V(OP_BAD, 0, 0, 0, 0, 0, 0, 3'd0, C_NONE, 0));
        step(V(OP_BAD, 0, 0, 0, 0, 0, 0, 3'd0, C_NONE, 0));
        chk("r_wb", {wb_RegWrite_o, wb_rd_o, wb_MemtoReg_o}, {1'b1, 5'd3, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Parametrised successor to the single-cycle decoder used in the 5-stage RISC-V pipeline.
- Decodes the ID-stage opcode and carries the control bits through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and injects bubbles.
- Honours an external freeze (e.g. a cache miss) and a branch flush, and counts stall cycles.

Parameters:
ALUOP_W, 3, ALUOp width; must be 3 when EN_UJ=1, may be 2 when EN_UJ=0
EN_UJ, 1, 1 = also decode jal/jalr/lui/auipc; 0 = RV32I subset only (R, I-ALU, lw, sw, beq)
REG_W, 5, register-index width
CNT_W, 16, stall-counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
Op_i  in  7  ID-stage opcode
rd_i  in  REG_W  ID-stage rd
rs1_i  in  REG_W  ID-stage rs1
rs2_i  in  REG_W  ID-stage rs2
hold_i  in  1  freeze all stage registers
flush_i  in  1  branch taken in ID; kill the ID instruction
stall_o  out  1  load-use stall; holds PC and IF/ID
ex_ALUOp_o  out  ALUOP_W  EX ALU operation class
ex_ALUSrc_o  out  1  EX operand B select: 1 = immediate
ex_Branch_o  out  1  EX instruction is beq
ex_Jump_o  out  1  EX instruction is jal/jalr (always 0 when EN_UJ=0)
ex_rd_o, mem_rd_o, wb_rd_o  out  REG_W  rd held in each stage
mem_MemRead_o, mem_MemWrite_o  out  1  MEM-stage memory controls
wb_RegWrite_o, wb_MemtoReg_o  out  1  WB-stage controls
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Decode (combinational, ID). ALUOp codes: 000 sub, 001 add, 010 R-funct, 011 I-funct, 100 pass-imm, 101 pc+4.
  - R 0110011: ALUOp 010; RegWrite.
  - I-ALU 0010011: ALUOp 011; ALUSrc; RegWrite.
  - lw 0000011: ALUOp 001; ALUSrc; RegWrite; MemtoReg; MemRead.
  - sw 0100011: ALUOp 001; ALUSrc; MemWrite.
  - beq 1100011: ALUOp 000; Branch.
  - EN_UJ=1 only:
    - jal 1101111: ALUOp 101; RegWrite; Jump.
    - jalr 1100111: ALUOp 101; RegWrite; Jump.
    - lui 0110111: ALUOp 100; ALUSrc; RegWrite.
    - auipc 0010111: ALUOp 001; ALUSrc; RegWrite.
  - Any other opcode decodes to a bubble (all controls 0, rd forced to 0).
- Register usage, for hazard detection:
  - rs1 is used by R, I-ALU, lw, sw, beq, jalr.
  - rs2 is used by R, sw, beq.
- Load-use detection: stall_o = ex_MemRead & ex_rd != 0 & ((rs1 used & rs1_i == ex_rd) | (rs2 used & rs2_i == ex_rd)) & !hold_i. Combinational; no added latency.
- Each rising edge, priority highest first:
  - hold_i=1: every stage register keeps its value; the counter is unchanged.
  - Otherwise EX/MEM <= ID/EX and MEM/WB <= EX/MEM. ID/EX loads a bubble if flush_i or stall_o; otherwise it loads the decoded ID controls plus rd_i.
- Stage contents:
  - ID/EX holds all controls plus rd.
  - EX/MEM holds MemRead, MemWrite, RegWrite, MemtoReg, rd.
  - MEM/WB holds RegWrite, MemtoReg, rd.
  - A bubble is all zeros including rd.
- flush_i and stall_o together: a single bubble is inserted. The stall count still increments.
- stall_cnt_o:
  - Increments on each clock where stall_o=1 (which implies hold_i=0).
  - Saturates at 2^CNT_W-1.
- Latency: an ID decode appears on ex_* one cycle later, mem_* two cycles later, wb_* three cycles later, excluding held cycles.
- Reset (rst_i=0, asynchronous):
  - Every stage register and stall_cnt_o clear to 0 immediately, which forces stall_o=0.
  - Reset mid-stream discards all in-flight instructions.
  - Decoding resumes on the first edge after rst_i rises.

Test Plan:
- Reset, then R-type (rd=3) in ID: cycle+1 ex_ALUOp_o=010, ex_ALUSrc_o=0; cycle+3 wb_RegWrite_o=1, wb_rd_o=3, wb_MemtoReg_o=0.
- lw x5 then add x6,x5,x1: stall_o=1 for exactly one cycle; next ID/EX is a bubble; stall_cnt_o=1; the add then reaches ex_* with ALUOp 010.
- lw x0 followed by a reader of x0: stall_o=0. lw x5 followed by lui x5 (no rs use): stall_o=0.
- hold_i=1 for 3 cycles mid-stream with sw in EX/MEM: mem_MemWrite_o stays 1 for all 4 cycles; stall_cnt_o unchanged.
- flush_i=1 with jal in ID: next ex_Jump_o=0 and ex_rd_o=0. Without flush: ex_Jump_o=1, ex_ALUOp_o=101. With EN_UJ=0, jal decodes to a bubble.
- Drive 2^CNT_W+5 consecutive load-use stalls (CNT_W=4): stall_cnt_o saturates at 15. Assert rst_i=0 mid-cycle: all outputs 0 before the next edge.
